kb_matrix_scanner: RTL and testbench

- Parametrised keypad matrix scanner; successor to the fixed 4x4 keyboard_row/keyboard_col scan inside the game top level.
- Drives active-low one-hot columns and samples active-low rows.
- Debounces every key and queues press, release and auto-repeat events in a FIFO with a valid/ready handshake.
- Sits between the board keypad pins and the game controller's position-entry logic.

---
 rtl/kb_matrix_scanner.sv | 135 +++++++++++++
 tb/tb_kb_matrix_scanner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/kb_matrix_scanner.sv
// kb_matrix_scanner: keypad matrix scanner with per-key debounce, auto-repeat and a press/release/repeat event FIFO
module kb_matrix_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DEBOUNCE     = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  localparam int KW          = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_tick,
  input  logic [ROWS-1:0]      keyboard_row,
  output logic [COLS-1:0]      keyboard_col,
  input  logic                 repeat_en,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [KW+1:0]        ev_data,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 any_pressed,
  output logic                 overflow,
  input  logic                 ovf_clr
);
  localparam int NK = ROWS*COLS;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(REPEAT_DELAY+1);
  localparam logic [1:0] S_IDLE = 2'd0, S_SAMPLE = 2'd1, S_PROC = 2'd2, S_ADV = 2'd3;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [ROWS-1:0] r_sync1, r_sync2, r_samp;
  logic [3:0]      r_cnt [NK];
  logic [NK-1:0]   r_stable;
  logic [KW-1:0]   r_tgt;
  logic            r_tgt_v;
  logic [TW-1:0]   r_rep;
  logic [KW+1:0]   r_mem [FIFO_DEPTH];
  logic [PW:0]     r_wp, r_rp;
  logic            r_ovf;

  logic [KW-1:0]   w_key;
  logic            w_raw, w_cur, w_flip, w_wrap, w_rep_push, w_push, w_pop, w_full, w_wr, w_drop;
  logic [3:0]      w_cnt_nx;
  logic [TW-1:0]   w_rep_nx;
  logic [KW+1:0]   w_push_data;
  logic [PW:0]     w_level;

  assign w_key       = KW'(int'(r_row) * COLS + int'(r_col));
  assign w_raw       = ~r_samp[RW'(ROWS-1) - r_row];
  assign w_cur       = r_stable[w_key];
  assign w_cnt_nx    = r_cnt[w_key] + 4'd1;
  assign w_flip      = r_state == S_PROC && w_raw != w_cur && w_cnt_nx == 4'(DEBOUNCE);
  assign w_wrap      = r_state == S_ADV && r_col == CW'(COLS-1);
  assign w_rep_nx    = r_rep + 1'b1;
  assign w_rep_push  = w_wrap && r_tgt_v && repeat_en && w_rep_nx == TW'(REPEAT_DELAY);
  assign w_push      = w_flip | w_rep_push;
  assign w_push_data = w_rep_push ? {2'b10, r_tgt} : {1'b0, w_raw, w_key};
  assign w_level     = r_wp - r_rp;
  assign w_full      = w_level == (PW+1)'(FIFO_DEPTH);
  assign w_pop       = ev_valid & ev_ready;
  assign w_wr        = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;

  assign keyboard_col = ~(COLS'(1) << (CW'(COLS-1) - r_col));
  assign ev_valid     = w_level != '0;
  assign ev_data      = ev_valid ? r_mem[r_rp[PW-1:0]] : '0;
  assign key_state    = r_stable;
  assign any_pressed  = |r_stable;
  assign overflow     = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_samp  <= '1;
    end else begin
      r_sync1 <= keyboard_row;
      r_sync2 <= r_sync1;
      r_state <= r_state == S_IDLE   ? (scan_tick ? S_SAMPLE : S_IDLE) :
                 r_state == S_SAMPLE ? S_PROC :
                 r_state == S_PROC   ? (r_row == RW'(ROWS-1) ? S_ADV : S_PROC) : S_IDLE;
      r_row   <= (r_state == S_PROC && r_row != RW'(ROWS-1)) ? r_row + 1'b1 : '0;
      if (r_state == S_SAMPLE) r_samp <= r_sync2;
      if (r_state == S_ADV) r_col <= r_col == CW'(COLS-1) ? '0 : r_col + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      for (int i = 0; i < NK; i++) r_cnt[i] <= '0;
    end else if (r_state == S_PROC) begin
      r_cnt[w_key] <= (w_raw == w_cur || w_flip) ? '0 : w_cnt_nx;
      if (w_flip) r_stable[w_key] <= w_raw;
    end
  end

  // Counter reloads to DELAY-RATE so later repeats land every RATE frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tgt   <= '0;
      r_tgt_v <= 1'b0;
      r_rep   <= '0;
    end else if (w_flip && w_raw) begin
      r_tgt   <= w_key;
      r_tgt_v <= 1'b1;
      r_rep   <= '0;
    end else if (w_flip && w_key == r_tgt) begin
      r_tgt_v <= 1'b0;
    end else if (w_wrap && r_tgt_v) begin
      r_rep <= !repeat_en ? '0 : w_rep_push ? TW'(REPEAT_DELAY - REPEAT_RATE) : w_rep_nx;
    end
  end

  always_ff @(posedge clk) if (w_wr) r_mem[r_wp[PW-1:0]] <= w_push_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_ovf <= w_drop | (r_ovf & ~ovf_clr);
    end
  end
endmodule

// File: tb/tb_kb_matrix_scanner.sv
// tb_kb_matrix_scanner: frame-level keypad model feeding a scoreboard; a monitor pops and compares every accepted event
module tb_kb_matrix_scanner;
  localparam int ROWS = 4, COLS = 4, DEB = 2, DEPTH = 8, RDLY = 16, RRATE = 4;
  localparam int NK = ROWS*COLS, KW = $clog2(NK);

  logic clk = 0, rst = 1, scan_tick = 0, repeat_en = 0, ev_ready = 0, ovf_clr = 0;
  logic [ROWS-1:0] keyboard_row;
  logic [COLS-1:0] keyboard_col;
  logic            ev_valid, any_pressed, overflow;
  logic [KW+1:0]   ev_data, mon_e;
  logic [NK-1:0]   key_state;

  logic [NK-1:0] mask = '0;
  int n_vec = 0, n_bad = 0, rdy_mode = 0;
  logic [KW+1:0] q[$];
  logic [NK-1:0] m_stable;
  int m_cnt[NK];
  int m_tgt, m_rep;
  bit hold = 0, exp_ovf = 0;

  kb_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH),
                      .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)) dut (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .keyboard_row(keyboard_row),
    .keyboard_col(keyboard_col), .repeat_en(repeat_en), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_data(ev_data), .key_state(key_state),
    .any_pressed(any_pressed), .overflow(overflow), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  // Physical matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    keyboard_row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mask[r*COLS+c] && !keyboard_col[COLS-1-c]) keyboard_row[ROWS-1-r] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ev_ready = rdy_mode == 2 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
    if (!rst && ev_valid && ev_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL ev_unexpected got=%h want=none", ev_data);
      end else begin
        mon_e = q.pop_front();
        chk("ev_data", 32'(ev_data), 32'(mon_e));
      end
    end
  end

  function automatic logic [COLS-1:0] col_of(input int c);
    logic [COLS-1:0] v = '1;
    v[COLS-1-c] = 1'b0;
    return v;
  endfunction

  function automatic void model_reset();
    m_stable = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_tgt = -1;
    m_rep = 0;
    exp_ovf = 0;
    q.delete();
  endfunction

  function automatic void push_exp(input logic [KW+1:0] e);
    if (hold && q.size() == DEPTH) exp_ovf = 1;
    else q.push_back(e);
  endfunction

  // One whole frame: keys visited column-major in scan order, repeat judged at the frame's end.
  function automatic void model_frame(input logic [NK-1:0] m);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        int k = r*COLS + c;
        if (m[k] == m_stable[k]) m_cnt[k] = 0;
        else if (++m_cnt[k] >= DEB) begin
          m_stable[k] = m[k];
          m_cnt[k] = 0;
          push_exp({1'b0, m[k], KW'(k)});
          if (m[k]) begin m_tgt = k; m_rep = 0; end
          else if (k == m_tgt) m_tgt = -1;
        end
      end
    if (m_tgt >= 0) begin
      m_rep = repeat_en ? m_rep + 1 : 0;
      if (m_rep >= RDLY && (m_rep - RDLY) % RRATE == 0) push_exp({2'b10, KW'(m_tgt)});
    end
  endfunction

  task automatic tick();
    @(negedge clk) scan_tick = 1;
    @(negedge clk) scan_tick = 0;
    repeat (ROWS+6) @(negedge clk);
  endtask

  task automatic frame(input logic [NK-1:0] m);
    mask = m;
    model_frame(m);
    for (int c = 0; c < COLS; c++) begin
      tick();
      chk("keyboard_col", 32'(keyboard_col), 32'(col_of((c+1) % COLS)));
    end
    chk("key_state", 32'(key_state), 32'(m_stable));
    chk("any_pressed", 32'(any_pressed), 32'(|m_stable));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic frames(input int n, input logic [NK-1:0] m);
    for (int i = 0; i < n; i++) frame(m);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk("drain_left", 32'(q.size()), 0);
    chk("drain_valid", 32'(ev_valid), 0);
  endtask

  task automatic check_reset_state();
    chk("rst_col", 32'(keyboard_col), 32'(col_of(0)));
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_data", 32'(ev_data), 0);
    chk("rst_key_state", 32'(key_state), 0);
    chk("rst_any", 32'(any_pressed), 0);
    chk("rst_ovf", 32'(overflow), 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 0;
    rdy_mode = 2;
    frames(8, '0);
    frames(3, NK'(1) << 10);
    frames(3, '0);
    for (int i = 0; i < 10; i++) frame(i % 2 == 0 ? NK'(1) << 5 : '0);
    frames(3, (NK'(1) << 4) | (NK'(1) << 6));
    frames(3, '0);
    repeat_en = 1;
    frames(30, NK'(1) << 3);
    repeat_en = 0;
    frames(20, NK'(1) << 3);
    frames(3, '0);
    drain();
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [NK-1:0] m = mask;
      int idx = $urandom_range(0, NK-1);
      if ($urandom_range(0, 1) == 1) m[idx] = ~m[idx];
      if ($urandom_range(0, 7) == 0) repeat_en = ~repeat_en;
      frame(m);
    end
    repeat_en = 0;
    rdy_mode = 2;
    frames(3, '0);
    drain();
    rdy_mode = 0;
    hold = 1;
    frames(2, NK'('h1F));
    frames(2, '0);
    chk("ovf_valid_held", 32'(ev_valid), 1);
    @(negedge clk) ovf_clr = 1;
    @(negedge clk) ovf_clr = 0;
    exp_ovf = 0;
    chk("ovf_cleared", 32'(overflow), 0);
    hold = 0;
    rdy_mode = 2;
    drain();
    rdy_mode = 0;
    hold = 1;
    frames(2, NK'(1) << 9);
    @(negedge clk) scan_tick = 1;
    @(negedge clk) scan_tick = 0;
    @(negedge clk) rst = 1;
    @(negedge clk);
    check_reset_state();
    rst = 0;
    hold = 0;
    model_reset();
    mask = '0;
    rdy_mode = 2;
    frames(3, '0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
